// File: rtl/mp_pkg.sv
// Shared constants, state encoding and helpers for the multi-precision datapath.
package mp_pkg;

  localparam int unsigned MP_WIDTH     = 1027;
  localparam int unsigned MP_SUM_WIDTH = 1028;

  // Same encoding as mpadder so state traces line up across the two blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB1 = 2'd1,
    ST_SUBN = 2'd2,
    ST_DONE = 2'd3
  } mp_state_e;

  // Number of limbs needed to cover the full sum width.
  function automatic int unsigned mp_cycles(input int unsigned limb_size);
    return (MP_SUM_WIDTH + limb_size - 1) / limb_size;
  endfunction

endpackage

// File: rtl/mp_limb_addc.sv
// Single-limb add with carry in and carry out: {cout, sum} = a + b + cin.
module mp_limb_addc #(
  parameter int unsigned W = 514
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c_o,
  output logic         cout_c_o
);

  localparam int unsigned WS = W + 1;

  logic [W:0] total_c;

  // Widen every operand by one bit so the carry lands in the MSB.
  assign total_c = WS'(a_i) + WS'(b_i) + WS'(cin_i);
  assign {cout_c_o, sum_c_o} = total_c;

endmodule

// File: rtl/mp_final_sub.sv
// Montgomery final conditional subtraction: returns (T >= M) ? T - M : T,
// computing T + ~M + 1 one limb per clock.
module mp_final_sub
  import mp_pkg::*;
#(
  parameter int unsigned LIMB_SIZE = 514
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [MP_SUM_WIDTH-1:0] in_t,
  input  logic [MP_WIDTH-1:0]     in_m,
  output logic [MP_WIDTH-1:0]     result,
  output logic                    subtracted,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CYCLE = mp_cycles(LIMB_SIZE);
  // Operands are padded to a whole number of limbs. Padding of T and M is
  // zero, so ~M contributes ones there and the carry out of the padded top
  // equals the carry out of bit MP_SUM_WIDTH-1.
  localparam int unsigned PAD_W = CYCLE * LIMB_SIZE;
  localparam int unsigned CNT_W = $clog2(CYCLE + 1);

  mp_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PAD_W-1:0]     t_q, t_d;
  logic [PAD_W-1:0]     m_q, m_d;
  logic [PAD_W-1:0]     diff_q, diff_d;
  logic [MP_WIDTH-1:0]  tcopy_q, tcopy_d;
  logic [MP_WIDTH-1:0]  result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 sub_q, sub_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [LIMB_SIZE-1:0] limb_a;
  logic [LIMB_SIZE-1:0] limb_b;
  logic [LIMB_SIZE-1:0] limb_sum;
  logic                 limb_cin;
  logic                 limb_cout;
  logic                 last_limb;

  // Current limb operands: low limb of T and inverted low limb of M.
  assign limb_a    = t_q[LIMB_SIZE-1:0];
  assign limb_b    = ~m_q[LIMB_SIZE-1:0];
  // The +1 of the two's complement enters as carry_in of limb 0.
  assign limb_cin  = (state_q == ST_SUB1) ? 1'b1 : carry_q;
  assign last_limb = (state_q == ST_SUB1) ? (CYCLE == 1)
                                          : (cnt_q == CNT_W'(CYCLE - 1));

  mp_limb_addc #(
    .W (LIMB_SIZE)
  ) u_addc (
    .a_i      (limb_a),
    .b_i      (limb_b),
    .cin_i    (limb_cin),
    .sum_c_o  (limb_sum),
    .cout_c_o (limb_cout)
  );

  // Next-state, operand shifting and output selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_d      = t_q;
    m_d      = m_q;
    diff_d   = diff_q;
    tcopy_d  = tcopy_q;
    carry_d  = carry_q;
    result_d = result_q;
    sub_d    = sub_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Transparent load so the start cycle captures the presented operands.
        t_d     = PAD_W'(in_t);
        m_d     = PAD_W'(in_m);
        tcopy_d = in_t[MP_WIDTH-1:0];
        cnt_d   = '0;
        if (start) begin
          state_d = ST_SUB1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SUB1, ST_SUBN: begin
        t_d     = t_q >> LIMB_SIZE;
        m_d     = m_q >> LIMB_SIZE;
        diff_d  = (diff_q >> LIMB_SIZE) | (PAD_W'(limb_sum) << (PAD_W - LIMB_SIZE));
        carry_d = limb_cout;
        cnt_d   = (state_q == ST_SUB1) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        if (last_limb) begin
          // Carry out set means no borrow, i.e. T >= M.
          state_d  = ST_DONE;
          done_d   = 1'b1;
          sub_d    = limb_cout;
          result_d = limb_cout ? diff_d[MP_WIDTH-1:0] : tcopy_q;
        end else begin
          state_d = ST_SUBN;
          busy_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers: state, limb counter, carry and handshake flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath registers: operand shifters, T copy, difference and outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t_q      <= '0;
      m_q      <= '0;
      diff_q   <= '0;
      tcopy_q  <= '0;
      result_q <= '0;
      sub_q    <= 1'b0;
    end else begin
      t_q      <= t_d;
      m_q      <= m_d;
      diff_q   <= diff_d;
      tcopy_q  <= tcopy_d;
      result_q <= result_d;
      sub_q    <= sub_d;
    end
  end

  assign result     = result_q;
  assign subtracted = sub_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
